// File: rtl/spy_readout_if.sv
// Word stream leaving the spy readout engine: one event per burst, last word flagged.
interface spy_stream_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH:0] out_data;
    logic                out_valid;
    logic                out_last;
    logic                out_ready;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/spy_readout.sv
// Walks the frozen spy event list from oldest slot to newest and streams each
// complete event's words out of spy memory as one valid/ready burst.
module spy_readout #(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WIDTH  = 7,
    parameter int META_SIZE  = 16,
    parameter int META_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic                  start,
    input  logic [META_WIDTH-1:0] meta_write_addr,
    output logic                  meta_read_enable,
    output logic [META_WIDTH-1:0] meta_read_addr,
    input  logic [MEM_WIDTH:0]    meta_read_data,
    output logic                  spy_read_enable,
    output logic [MEM_WIDTH-1:0]  spy_read_addr,
    input  logic [DATA_WIDTH:0]   spy_data,
    spy_stream_if.master          out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [META_WIDTH:0]   event_count
);
    typedef enum logic [2:0] {
        IDLE, META_RD, META_WAIT, DATA_RD, DATA_WAIT, HOLD, FINISH
    } state_t;

    localparam logic [META_WIDTH:0] SCAN_LIMIT = (META_WIDTH+1)'(META_SIZE);

    state_t                state_q, state_d;
    logic [META_WIDTH-1:0] slot_q, slot_d;
    logic [META_WIDTH:0]   scanned_q, scanned_d;
    logic                  have_boundary_q, have_boundary_d;
    logic [MEM_WIDTH-1:0]  prev_end_q, prev_end_d;
    logic [MEM_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [MEM_WIDTH-1:0]  ev_end_q, ev_end_d;
    logic [META_WIDTH:0]   event_count_q, event_count_d;
    logic [DATA_WIDTH:0]   out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  meta_re_q, meta_re_d;
    logic [META_WIDTH-1:0] meta_addr_q, meta_addr_d;
    logic                  spy_re_q, spy_re_d;
    logic [MEM_WIDTH-1:0]  spy_addr_q, spy_addr_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  advance;

    logic                  entry_valid;
    logic [MEM_WIDTH-1:0]  entry_end;

    assign entry_valid = meta_read_data[MEM_WIDTH];
    assign entry_end   = meta_read_data[MEM_WIDTH-1:0];

    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        scanned_d       = scanned_q;
        have_boundary_d = have_boundary_q;
        prev_end_d      = prev_end_q;
        rd_ptr_d        = rd_ptr_q;
        ev_end_d        = ev_end_q;
        event_count_d   = event_count_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        out_last_d      = out_last_q;
        meta_re_d       = 1'b0;
        meta_addr_d     = meta_addr_q;
        spy_re_d        = 1'b0;
        spy_addr_d      = spy_addr_q;
        done_d          = 1'b0;
        aborted_d       = 1'b0;
        advance         = 1'b0;

        // Losing freeze means the memories may be overwritten: drop everything, even a pending handshake.
        if (state_q != IDLE && !freeze) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            aborted_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && freeze) begin
                        slot_d          = meta_write_addr;
                        scanned_d       = '0;
                        have_boundary_d = 1'b0;
                        event_count_d   = '0;
                        meta_re_d       = 1'b1;
                        meta_addr_d     = meta_write_addr;
                        state_d         = META_RD;
                    end
                end
                META_RD: state_d = META_WAIT;
                META_WAIT: begin
                    // The first valid entry only marks where the next event begins; its own start may be overwritten.
                    if (!entry_valid || !have_boundary_q || entry_end == prev_end_q) begin
                        if (entry_valid && !have_boundary_q) begin
                            prev_end_d      = entry_end;
                            have_boundary_d = 1'b1;
                        end
                        advance = 1'b1;
                    end else begin
                        rd_ptr_d   = prev_end_q + MEM_WIDTH'(1);
                        ev_end_d   = entry_end;
                        prev_end_d = entry_end;
                        spy_re_d   = 1'b1;
                        spy_addr_d = prev_end_q + MEM_WIDTH'(1);
                        state_d    = DATA_RD;
                    end
                end
                DATA_RD: state_d = DATA_WAIT;
                DATA_WAIT: begin
                    out_data_d  = spy_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_ptr_q == ev_end_q);
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_if.out_ready) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        if (out_last_q) begin
                            event_count_d = event_count_q + (META_WIDTH+1)'(1);
                            advance       = 1'b1;
                        end else begin
                            rd_ptr_d   = rd_ptr_q + MEM_WIDTH'(1);
                            spy_re_d   = 1'b1;
                            spy_addr_d = rd_ptr_q + MEM_WIDTH'(1);
                            state_d    = DATA_RD;
                        end
                    end
                end
                FINISH: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (advance) begin
                slot_d    = slot_q + META_WIDTH'(1);
                scanned_d = scanned_q + (META_WIDTH+1)'(1);
                if (scanned_q + (META_WIDTH+1)'(1) == SCAN_LIMIT) begin
                    state_d = FINISH;
                end else begin
                    meta_re_d   = 1'b1;
                    meta_addr_d = slot_q + META_WIDTH'(1);
                    state_d     = META_RD;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            slot_q          <= '0;
            scanned_q       <= '0;
            have_boundary_q <= 1'b0;
            prev_end_q      <= '0;
            rd_ptr_q        <= '0;
            ev_end_q        <= '0;
            event_count_q   <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            meta_re_q       <= 1'b0;
            meta_addr_q     <= '0;
            spy_re_q        <= 1'b0;
            spy_addr_q      <= '0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            scanned_q       <= scanned_d;
            have_boundary_q <= have_boundary_d;
            prev_end_q      <= prev_end_d;
            rd_ptr_q        <= rd_ptr_d;
            ev_end_q        <= ev_end_d;
            event_count_q   <= event_count_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            meta_re_q       <= meta_re_d;
            meta_addr_q     <= meta_addr_d;
            spy_re_q        <= spy_re_d;
            spy_addr_q      <= spy_addr_d;
            done_q          <= done_d;
            aborted_q       <= aborted_d;
        end
    end

    assign meta_read_enable = meta_re_q;
    assign meta_read_addr   = meta_addr_q;
    assign spy_read_enable  = spy_re_q;
    assign spy_read_addr    = spy_addr_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign aborted          = aborted_q;
    assign event_count      = event_count_q;
endmodule
